// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams a contiguous, wrapping run of words from a
// 512x32 block RAM read port onto a valid/ready interface. A 4-entry output
// FIFO absorbs the one-cycle RAM latency and downstream back-pressure while
// still allowing one word per cycle.
module bram_stream_reader #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic [ADDR_W-1:0] base_addr_in,
  input  logic [ADDR_W:0]   len_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              bram_en_out,
  output logic [3:0]        bram_we_out,
  output logic [ADDR_W-1:0] bram_addr_out,
  input  logic [DATA_W-1:0] bram_rd_d_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              last_out
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(1) << ADDR_W;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;     // reads not yet issued, incl. one issuing now
  logic              en_q, en_d;
  logic              pend_q;           // read issued last cycle; data on bram_rd_d_in now
  logic              pend_last_q;      // ...and it was the final read of the transfer
  logic              last_issue;
  logic              done_q, done_d;

  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
  logic              last_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;
  logic [CNT_W:0]    occ_next;
  logic [LEN_W-1:0]  len_clamped;

  // FIFO push/pop and next occupancy
  always_comb begin
    push        = pend_q;
    pop         = valid_out & ready_in;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    // Occupancy next cycle counting the read that will still be in flight.
    occ_next    = {1'b0, count_d} + (CNT_W + 1)'(en_q);
    len_clamped = (len_in > MaxLen) ? MaxLen : len_in;
    last_issue  = en_q && (rem_q == LEN_W'(1));
  end

  // Control FSM next-state and registered-output next values
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The done cycle is still part of the transfer: ignore start there.
        if (start_in && !done_q) begin
          if (len_in == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StRead;
            addr_d  = base_addr_in;
            rem_d   = len_clamped;
            en_d    = 1'b1;
          end
        end
      end
      StRead: begin
        if (en_q) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
        end
        if (last_issue) begin
          state_d = StDrain;
        end else begin
          en_d = occ_next < (CNT_W + 1)'(FIFO_DEPTH);
        end
      end
      StDrain: begin
        if (pop && last_out) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      rem_q       <= '0;
      en_q        <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      en_q        <= en_d;
      pend_q      <= en_q;
      pend_last_q <= last_issue;
      done_q      <= done_d;
    end
  end

  // Output FIFO storage and pointers; storage cleared so data_out reads 0 after reset
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        last_mem_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        data_mem_q[wr_ptr_q] <= bram_rd_d_in;
        last_mem_q[wr_ptr_q] <= pend_last_q;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Outputs straight from registers
  always_comb begin
    busy_out      = state_q != StIdle;
    done_out      = done_q;
    bram_en_out   = en_q;
    bram_we_out   = 4'h0;
    bram_addr_out = addr_q;
    valid_out     = count_q != '0;
    data_out      = data_mem_q[rd_ptr_q];
    last_out      = valid_out & last_mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: a RAM model answers reads, the
// stimulus process queues expected addresses and words, and a monitor
// process pops and compares whatever the DUT issues or delivers.
module tb_bram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  base;
  logic [9:0]  len;
  logic        busy, done, bram_en;
  logic [3:0]  bram_we;
  logic [8:0]  bram_addr;
  logic [31:0] bram_rd_d;
  logic [31:0] data;
  logic        valid, ready, last;

  logic [31:0] ram [512];

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_word_q [$];
  logic [8:0]  exp_addr_q [$];
  int issued = 0;
  int issued_before_pop = -1;
  int lasts = 0;

  always #5 clk = ~clk;

  bram_stream_reader dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .start_in      (start),
    .base_addr_in  (base),
    .len_in        (len),
    .busy_out      (busy),
    .done_out      (done),
    .bram_en_out   (bram_en),
    .bram_we_out   (bram_we),
    .bram_addr_out (bram_addr),
    .bram_rd_d_in  (bram_rd_d),
    .data_out      (data),
    .valid_out     (valid),
    .ready_in      (ready),
    .last_out      (last)
  );

  // One-cycle registered read port
  always @(posedge clk) begin
    if (bram_en) bram_rd_d <= ram[bram_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue expectations for a transfer; clamps like the design must
  task automatic expect_xfer(input int b, input int n);
    int m;
    m = (n > 512) ? 512 : n;
    for (int i = 0; i < m; i++) begin
      exp_addr_q.push_back(9'((b + i) % 512));
      exp_word_q.push_back({(i == m - 1) ? 1'b1 : 1'b0, ram[(b + i) % 512]});
    end
  endtask

  task automatic issue_start(input int b, input int n);
    base  = 9'(b);
    len   = 10'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int i;
    i = 0;
    while (!done && i < limit) begin
      tick();
      i++;
    end
    check(name, {63'd0, done}, 64'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"},  {63'd0, busy}, 64'd0);
    check({name, "_done"},  {63'd0, done}, 64'd0);
    check({name, "_en"},    {63'd0, bram_en}, 64'd0);
    check({name, "_addr"},  {55'd0, bram_addr}, 64'd0);
    check({name, "_valid"}, {63'd0, valid}, 64'd0);
    check({name, "_last"},  {63'd0, last}, 64'd0);
    check({name, "_data"},  {32'd0, data}, 64'd0);
  endtask

  // base=5 len=4 with ready high: exact cycle-by-cycle behaviour
  task automatic run_basic(input string name);
    expect_xfer(5, 4);
    ready = 1'b1;
    issue_start(5, 4);
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("%s_valid_c%0d", name, c), {63'd0, valid},
            {63'd0, (c >= 3 && c <= 6) ? 1'b1 : 1'b0});
      check($sformatf("%s_last_c%0d", name, c), {63'd0, last}, {63'd0, (c == 6) ? 1'b1 : 1'b0});
      check($sformatf("%s_done_c%0d", name, c), {63'd0, done}, {63'd0, (c == 7) ? 1'b1 : 1'b0});
      check($sformatf("%s_busy_c%0d", name, c), {63'd0, busy},
            {63'd0, (c >= 1 && c <= 6) ? 1'b1 : 1'b0});
      check($sformatf("%s_we_c%0d", name, c), {60'd0, bram_we}, 64'd0);
      if (c == 1) check({name, "_first_addr"}, {55'd0, bram_addr}, 64'd5);
      tick();
    end
    check({name, "_words_left"}, exp_word_q.size(), 64'd0);
  endtask

  // Monitor: compares every issued read and every delivered word
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (valid && ready) begin
          if (issued_before_pop < 0) issued_before_pop = issued;
          if (last) lasts++;
          if (exp_word_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual=%0h required=none", data);
          end else begin
            check("word", {31'd0, last, data}, {31'd0, exp_word_q.pop_front()});
          end
        end
        if (bram_en) begin
          issued++;
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read actual=%0h required=none", bram_addr);
          end else begin
            check("read_addr", {55'd0, bram_addr}, {55'd0, exp_addr_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 32'hA000_0000 + 32'(i);
    rst_n = 1'b0;
    start = 1'b0;
    base  = '0;
    len   = '0;
    ready = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Basic transfer
    run_basic("basic");

    // Back-pressure: ready low on cycles 3..8, longer run to stress the FIFO bound
    expect_xfer(5, 8);
    issued = 0;
    issued_before_pop = -1;
    ready = 1'b1;
    issue_start(5, 8);
    for (int c = 1; c <= 9; c++) begin
      ready = (c >= 3 && c <= 8) ? 1'b0 : 1'b1;
      tick();
    end
    ready = 1'b1;
    wait_done("bp_done", 40);
    check("bp_reads_before_pop_le4", {63'd0, (issued_before_pop >= 0 && issued_before_pop <= 4)},
          64'd1);
    check("bp_words_left", exp_word_q.size(), 64'd0);
    check("bp_total_reads", issued, 64'd8);
    tick();

    // Wrap-around
    expect_xfer(510, 4);
    issue_start(510, 4);
    wait_done("wrap_done", 20);
    check("wrap_words_left", exp_word_q.size(), 64'd0);
    tick();

    // len=0 no-op
    issued = 0;
    issue_start(7, 0);
    check("len0_done", {63'd0, done}, 64'd1);
    check("len0_busy", {63'd0, busy}, 64'd0);
    check("len0_en", {63'd0, bram_en}, 64'd0);
    tick();
    check("len0_done_clear", {63'd0, done}, 64'd0);
    check("len0_busy_after", {63'd0, busy}, 64'd0);
    tick();
    check("len0_reads", issued, 64'd0);

    // len=600 clamps to 512
    lasts = 0;
    expect_xfer(100, 600);
    issue_start(100, 600);
    wait_done("clamp_done", 700);
    check("clamp_words_left", exp_word_q.size(), 64'd0);
    check("clamp_lasts", lasts, 64'd1);
    tick();

    // Start while busy and on the done cycle are ignored
    issued = 0;
    expect_xfer(20, 8);
    issue_start(20, 8);
    tick();
    tick();
    base  = 9'd300;
    len   = 10'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign_done", 40);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_busy_after_done", {63'd0, busy}, 64'd0);
    check("ign_done_once", {63'd0, done}, 64'd0);
    tick();
    tick();
    check("ign_reads", issued, 64'd8);
    check("ign_words_left", exp_word_q.size(), 64'd0);

    // Reset mid-transfer, then a fresh transfer behaves normally
    expect_xfer(40, 8);
    issue_start(40, 8);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    exp_word_q.delete();
    exp_addr_q.delete();
    tick();
    rst_n = 1'b1;
    check_reset_outputs("midreset");
    tick();
    check("midreset_idle_valid", {63'd0, valid}, 64'd0);
    run_basic("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
